dla_platform_reset_sequencer: RTL and testbench
===============================================

Name: dla_platform_reset_sequencer

Overview:
Single-clock-domain reset sequencer for the DLA platform. It synchronizes deassertion of an asynchronous reset and holds all outputs in reset for a programmable time. It then releases NUM_STAGES reset outputs in a staged order, and supports a software-requested re-reset preceded by a quiesce handshake with timeout. One instance sits in each clock domain, driving that domain's datapath, control and interface resets in order.

Parameters:
NUM_STAGES, 3, number of staged reset outputs; stage 0 releases first (>=1)
SYNC_DEPTH, 3, flops in the aclrn deassertion synchronizer (>=2)
HOLD_CYCLES, 16, cycles all outputs stay in reset after the synchronized reset exits or a soft reset ends (>=1)
STAGE_GAP_CYCLES, 4, cycles between release of stage k-1 and stage k (>=1)
QUIESCE_TIMEOUT_CYCLES, 256, maximum cycles to wait for i_quiesce_ack (>=1)

Ports:
clk  input  1  clock
aclrn  input  1  reset, asynchronous, active-low
i_soft_reset_req  input  1  level, synchronous to clk; requests a full re-reset of the domain
i_quiesce_ack  input  1  synchronous to clk; downstream logic is idle and may be reset
o_quiesce_req  output  1  asks downstream logic to drain or idle
o_resetn  output  NUM_STAGES  staged active-low resets; bit 0 releases first
o_all_released  output  1  high when every o_resetn bit is high
o_busy  output  1  high in every state except RUN
o_timeout_sticky  output  1  set when a quiesce timed out; cleared only by aclrn

Behaviour:
- All flops enter reset asynchronously on aclrn low and exit synchronously. Reset values: o_resetn='0, o_quiesce_req=0, o_all_released=0, o_busy=1, o_timeout_sticky=0, state=HOLD, counters=0.
- Internal rst_sync rises SYNC_DEPTH rising edges after aclrn deasserts. The FSM is frozen while rst_sync=0.
- All outputs are registered and glitch-free.
- Counter width is $clog2(max(HOLD_CYCLES, STAGE_GAP_CYCLES, QUIESCE_TIMEOUT_CYCLES))+1, computed by the package function. Counters saturate and never wrap.
- States:
  - HOLD: all o_resetn=0. The counter increments only while i_soft_reset_req=0; it clears whenever the request is high, which extends reset. After HOLD_CYCLES consecutive cycles with the request low, go to RELEASE and set o_resetn[0]=1 on that edge.
  - With no request, o_resetn[0] rises exactly SYNC_DEPTH+HOLD_CYCLES edges after aclrn deasserts.
  - RELEASE: o_resetn[k] rises exactly STAGE_GAP_CYCLES edges after o_resetn[k-1]. When the last bit rises, go to RUN and raise o_all_released on the same edge. If NUM_STAGES=1, go directly from HOLD to RUN.
  - RELEASE ignores i_soft_reset_req. A request still high when RUN is entered is serviced on the first RUN cycle.
  - RUN: o_busy=0. If i_soft_reset_req=1 is sampled, go to QUIESCE and set o_quiesce_req=1 on the next edge.
  - QUIESCE: o_resetn is unchanged and the timeout counter runs.
    - If i_quiesce_ack is sampled high, then on the next edge: o_resetn='0 (all bits together), o_all_released=0, o_quiesce_req=0, state=HOLD.
    - If QUIESCE_TIMEOUT_CYCLES cycles elapse with no ack, take the same action and also set o_timeout_sticky=1.
    - If ack arrives on the timeout cycle itself, ack wins and the sticky bit is not set.
  - i_quiesce_ack outside QUIESCE is ignored.
- If aclrn asserts in any state, all outputs drop immediately (asynchronously) and the sequence restarts from HOLD once rst_sync rises.

Decomposition:
- Package dla_platform_reset_pkg:
  - state enum typedef {HOLD, RELEASE, RUN, QUIESCE}
  - function counter_width(a,b,c)
  - parameter-legality checks as elaboration-time assertions
- Sub-module dla_platform_reset_sync, parameter SYNC_DEPTH: async-assert / sync-deassert shift chain producing rst_sync.
- Stage counter and FSM live in the top module.

Test Plan:
- Power-up, default parameters, request low: deassert aclrn -> o_resetn[0] rises at edge 19, o_resetn[1] at 23, o_resetn[2] and o_all_released at 27; o_busy falls at 27.
- In RUN, pulse i_soft_reset_req for 1 cycle and assert ack 5 cycles after o_quiesce_req rises -> o_resetn goes to 000 one edge after ack sampled, o_quiesce_req drops, re-release follows 16/4/4 cycle spacing, o_timeout_sticky=0.
- In RUN, assert request and never ack -> o_quiesce_req stays high for exactly 256 cycles, then o_resetn=000 and o_timeout_sticky=1; the sticky bit persists through re-release and clears only on aclrn.
- Hold i_soft_reset_req high for 50 cycles after the quiesce completes -> o_resetn stays 000 throughout; o_resetn[0] rises exactly 16 cycles after the request falls.
- Assert aclrn mid-RELEASE (after stage 1 released) -> o_resetn=000 asynchronously with no clock, and the full sequence repeats after deassertion.
- Ack on the same cycle the timeout expires -> reset proceeds and o_timeout_sticky stays 0. Also run NUM_STAGES=1 and HOLD_CYCLES=1 corner builds and check the timing formulas.

Source files
------------

// File: rtl/dla_platform_reset_sequencer_pkg.sv
// Package for the DLA platform reset sequencer.
// Contents:
//   state_e        - sequencer FSM states
//   counter_width  - width of the shared hold/gap/timeout counter
//   params_legal   - parameter legality predicate used at elaboration
package dla_platform_reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    QUIESCE = 2'd3
  } state_e;

  // One counter serves all three timed phases, so it is sized for the
  // largest of them. The extra bit leaves headroom for saturation.
  function automatic int counter_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

  function automatic bit params_legal(input int num_stages, input int sync_depth,
                                      input int hold_cycles, input int gap_cycles,
                                      input int timeout_cycles);
    return (num_stages >= 1) && (sync_depth >= 2) && (hold_cycles >= 1) &&
           (gap_cycles >= 1) && (timeout_cycles >= 1);
  endfunction

endpackage

// File: rtl/dla_platform_reset_sequencer_if.sv
// Interface bundling the sequencer's handshake and reset outputs.
// Quiesce handshake: the sequencer raises o_quiesce_req and holds it until it
// samples i_quiesce_ack high (or its timeout expires); the ack is only
// meaningful while the request is high and is ignored at any other time.
//   master: sequencer side (drives resets, quiesce request, status)
//   slave : domain side (drives soft reset request and quiesce ack)
interface dla_platform_reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  import dla_platform_reset_pkg::*;

  logic                  i_soft_reset_req;
  logic                  i_quiesce_ack;
  logic                  o_quiesce_req;
  logic [NUM_STAGES-1:0] o_resetn;
  logic                  o_all_released;
  logic                  o_busy;
  logic                  o_timeout_sticky;
  state_e                o_dbg_state;

  modport master (
    input  i_soft_reset_req, i_quiesce_ack,
    output o_quiesce_req, o_resetn, o_all_released, o_busy, o_timeout_sticky,
           o_dbg_state
  );

  modport slave (
    output i_soft_reset_req, i_quiesce_ack,
    input  o_quiesce_req, o_resetn, o_all_released, o_busy, o_timeout_sticky,
           o_dbg_state
  );
endinterface

// File: rtl/dla_platform_reset_sequencer_sync.sv
// Reset synchronizer: asserts asynchronously with aclrn, deasserts
// SYNC_DEPTH rising edges after aclrn goes high.
// Ports: clk, aclrn (async active-low), o_rst_sync (high = out of reset).
module dla_platform_reset_sync #(
  parameter int SYNC_DEPTH = 3
) (
  input  logic clk,
  input  logic aclrn,
  output logic o_rst_sync
);

  logic [SYNC_DEPTH-1:0] r_chain;

  always_ff @(posedge clk or negedge aclrn) begin
    if (!aclrn) r_chain <= '0;
    else        r_chain <= {r_chain[SYNC_DEPTH-2:0], 1'b1};
  end

  assign o_rst_sync = r_chain[SYNC_DEPTH-1];

endmodule

// File: rtl/dla_platform_reset_sequencer.sv
// DLA platform reset sequencer: holds a clock domain in reset, releases
// NUM_STAGES active-low resets in order, and performs quiesce-guarded soft
// re-resets on request.
// Ports: clk, aclrn (async active-low), bus (master modport carrying the
// soft reset request, quiesce handshake, staged resets and status flags).
module dla_platform_reset_sequencer
  import dla_platform_reset_pkg::*;
#(
  parameter int NUM_STAGES             = 3,
  parameter int SYNC_DEPTH             = 3,
  parameter int HOLD_CYCLES            = 16,
  parameter int STAGE_GAP_CYCLES       = 4,
  parameter int QUIESCE_TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           aclrn,
  dla_platform_reset_sequencer_if.master bus
);

  if (!params_legal(NUM_STAGES, SYNC_DEPTH, HOLD_CYCLES, STAGE_GAP_CYCLES,
                    QUIESCE_TIMEOUT_CYCLES)) begin : g_param_check
    $error("dla_platform_reset_sequencer: illegal parameter set");
  end

  localparam int CW = counter_width(HOLD_CYCLES, STAGE_GAP_CYCLES,
                                    QUIESCE_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(QUIESCE_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic                  w_rst_sync;
  state_e                r_state,  w_state_next;
  logic [CW-1:0]         r_cnt,    w_cnt_next,  w_cnt_inc;
  logic [NUM_STAGES-1:0] r_resetn, w_resetn_next, w_resetn_shift;
  logic                  r_qreq,   w_qreq_next;
  logic                  r_sticky, w_sticky_next;
  logic                  r_all_released;
  logic                  r_busy;

  dla_platform_reset_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
    .clk        (clk),
    .aclrn      (aclrn),
    .o_rst_sync (w_rst_sync)
  );

  // Saturating increment; the counter never wraps.
  assign w_cnt_inc      = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
  // Next stage to release: shift a one in from bit 0.
  assign w_resetn_shift = (r_resetn << 1) | NUM_STAGES'(1);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_resetn_next = r_resetn;
    w_qreq_next   = r_qreq;
    w_sticky_next = r_sticky;
    case (r_state)
      HOLD: begin
        // A pending request restarts the hold window.
        if (bus.i_soft_reset_req) begin
          w_cnt_next = '0;
        end else if (r_cnt >= HOLD_LAST) begin
          w_cnt_next    = '0;
          w_resetn_next = NUM_STAGES'(1);
          w_state_next  = (NUM_STAGES == 1) ? RUN : RELEASE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      RELEASE: begin
        if (r_cnt >= GAP_LAST) begin
          w_cnt_next    = '0;
          w_resetn_next = w_resetn_shift;
          if (&w_resetn_shift) w_state_next = RUN;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      RUN: begin
        if (bus.i_soft_reset_req) begin
          w_state_next = QUIESCE;
          w_qreq_next  = 1'b1;
          w_cnt_next   = '0;
        end
      end
      QUIESCE: begin
        // Ack takes priority over a simultaneous timeout.
        if (bus.i_quiesce_ack || (r_cnt >= TO_LAST)) begin
          w_state_next  = HOLD;
          w_resetn_next = '0;
          w_qreq_next   = 1'b0;
          w_cnt_next    = '0;
          if (!bus.i_quiesce_ack) w_sticky_next = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: w_state_next = HOLD;
    endcase
  end

  // Status flags are registered from the next-state values so they change on
  // the same edge as the resets they describe.
  always_ff @(posedge clk or negedge aclrn) begin
    if (!aclrn) begin
      r_state        <= HOLD;
      r_cnt          <= '0;
      r_resetn       <= '0;
      r_qreq         <= 1'b0;
      r_sticky       <= 1'b0;
      r_all_released <= 1'b0;
      r_busy         <= 1'b1;
    end else if (w_rst_sync) begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_resetn       <= w_resetn_next;
      r_qreq         <= w_qreq_next;
      r_sticky       <= w_sticky_next;
      r_all_released <= &w_resetn_next;
      r_busy         <= (w_state_next != RUN);
    end
  end

  assign bus.o_resetn         = r_resetn;
  assign bus.o_quiesce_req    = r_qreq;
  assign bus.o_all_released   = r_all_released;
  assign bus.o_busy           = r_busy;
  assign bus.o_timeout_sticky = r_sticky;
  assign bus.o_dbg_state      = r_state;

endmodule

// File: tb/tb_dla_platform_reset_sequencer.sv
// Testbench for dla_platform_reset_sequencer: a default-parameter instance
// (d0) and a corner instance (d1: one stage, one hold cycle) run side by side
// against a cycle-level reference model of the release/quiesce timeline.
module tb_dla_platform_reset_sequencer;
  import dla_platform_reset_pkg::*;

  localparam int N0 = 3, SD0 = 3, H0 = 16, G0 = 4, TO0 = 256;
  localparam int N1 = 1, SD1 = 2, H1 = 1,  G1 = 1, TO1 = 8;

  localparam int PH_HOLD = 0, PH_REL = 1, PH_RUN = 2, PH_Q = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aclrn = 1'b0;
  always #5 clk = ~clk;

  logic req_v [2];
  logic ack_v [2];

  dla_platform_reset_sequencer_if #(.NUM_STAGES(N0)) if0 ();
  dla_platform_reset_sequencer_if #(.NUM_STAGES(N1)) if1 ();

  assign if0.i_soft_reset_req = req_v[0];
  assign if0.i_quiesce_ack    = ack_v[0];
  assign if1.i_soft_reset_req = req_v[1];
  assign if1.i_quiesce_ack    = ack_v[1];

  dla_platform_reset_sequencer #(
    .NUM_STAGES(N0), .SYNC_DEPTH(SD0), .HOLD_CYCLES(H0),
    .STAGE_GAP_CYCLES(G0), .QUIESCE_TIMEOUT_CYCLES(TO0)
  ) dut0 (.clk(clk), .aclrn(aclrn), .bus(if0));

  dla_platform_reset_sequencer #(
    .NUM_STAGES(N1), .SYNC_DEPTH(SD1), .HOLD_CYCLES(H1),
    .STAGE_GAP_CYCLES(G1), .QUIESCE_TIMEOUT_CYCLES(TO1)
  ) dut1 (.clk(clk), .aclrn(aclrn), .bus(if1));

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  bit rand1_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the domain's timeline: how many sync edges have passed, which
  // phase we are in, cycles spent in it, and how many stages are released.
  int m_sync [2];
  int m_phase[2];
  int m_el   [2];
  int m_rel  [2];
  bit m_sticky[2];

  function automatic int p_n (input int k); return (k == 0) ? N0  : N1;  endfunction
  function automatic int p_sd(input int k); return (k == 0) ? SD0 : SD1; endfunction
  function automatic int p_h (input int k); return (k == 0) ? H0  : H1;  endfunction
  function automatic int p_g (input int k); return (k == 0) ? G0  : G1;  endfunction
  function automatic int p_to(input int k); return (k == 0) ? TO0 : TO1; endfunction

  task automatic model_reset(input int k);
    m_sync[k] = 0; m_phase[k] = PH_HOLD; m_el[k] = 0; m_rel[k] = 0; m_sticky[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    if (!aclrn) begin
      model_reset(k);
      return;
    end
    if (m_sync[k] < p_sd(k)) begin
      m_sync[k]++;
      return;
    end
    case (m_phase[k])
      PH_HOLD: begin
        if (req_v[k]) m_el[k] = 0;
        else begin
          m_el[k]++;
          if (m_el[k] == p_h(k)) begin
            m_rel[k] = 1;
            m_el[k] = 0;
            m_phase[k] = (m_rel[k] == p_n(k)) ? PH_RUN : PH_REL;
          end
        end
      end
      PH_REL: begin
        m_el[k]++;
        if (m_el[k] == p_g(k)) begin
          m_rel[k]++;
          m_el[k] = 0;
          if (m_rel[k] == p_n(k)) m_phase[k] = PH_RUN;
        end
      end
      PH_RUN: begin
        if (req_v[k]) begin
          m_phase[k] = PH_Q;
          m_el[k] = 0;
        end
      end
      default: begin
        m_el[k]++;
        if (ack_v[k] || (m_el[k] == p_to(k))) begin
          if (!ack_v[k]) m_sticky[k] = 1'b1;
          m_phase[k] = PH_HOLD;
          m_rel[k] = 0;
          m_el[k] = 0;
        end
      end
    endcase
  endtask

  task automatic check_outputs(input int k);
    logic [31:0] a_rn;
    logic a_ar, a_busy, a_q, a_st, a_run;
    if (k == 0) begin
      a_rn = 32'(if0.o_resetn); a_ar = if0.o_all_released; a_busy = if0.o_busy;
      a_q = if0.o_quiesce_req; a_st = if0.o_timeout_sticky; a_run = (if0.o_dbg_state == RUN);
    end else begin
      a_rn = 32'(if1.o_resetn); a_ar = if1.o_all_released; a_busy = if1.o_busy;
      a_q = if1.o_quiesce_req; a_st = if1.o_timeout_sticky; a_run = (if1.o_dbg_state == RUN);
    end
    check($sformatf("d%0d_resetn", k), a_rn, (32'd1 << m_rel[k]) - 32'd1);
    check($sformatf("d%0d_all_released", k), 32'(a_ar), 32'(m_rel[k] == p_n(k)));
    check($sformatf("d%0d_busy", k), 32'(a_busy), 32'(m_phase[k] != PH_RUN));
    check($sformatf("d%0d_quiesce_req", k), 32'(a_q), 32'(m_phase[k] == PH_Q));
    check($sformatf("d%0d_timeout_sticky", k), 32'(a_st), 32'(m_sticky[k]));
    check($sformatf("d%0d_state_run", k), 32'(a_run), 32'(m_phase[k] == PH_RUN));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model and DUT both see the inputs at the rising edge, outputs
  // are checked on the falling edge, then d1 gets fresh random inputs.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_outputs(0);
    check_outputs(1);
    if (rand1_en) begin
      req_v[1] = ($urandom_range(0, 19) == 0);
      ack_v[1] = ($urandom_range(0, 5) == 0);
    end
  endtask

  function automatic bit cond0(input int which);
    case (which)
      0:       return if0.o_quiesce_req;
      1:       return !if0.o_quiesce_req;
      2:       return if0.o_all_released;
      default: return if0.o_resetn[1];
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (cond0(which)) return;
      tick();
    end
    check({tag, "_wait_expired"}, 32'd0, 32'd1);
  endtask

  // Called at a falling edge: assert aclrn between edges, verify the
  // asynchronous drop, hold two cycles, release on a falling edge.
  task automatic do_aclr();
    #2 aclrn = 1'b0;
    #1;
    check("async_d0_resetn", 32'(if0.o_resetn), 32'd0);
    check("async_d0_flags", {29'd0, if0.o_all_released, if0.o_quiesce_req,
                             if0.o_timeout_sticky}, 32'd0);
    check("async_d0_busy", 32'(if0.o_busy), 32'd1);
    check("async_d1_resetn", 32'(if1.o_resetn), 32'd0);
    check("async_d1_sticky", 32'(if1.o_timeout_sticky), 32'd0);
    model_reset(0);
    model_reset(1);
    tick();
    tick();
    aclrn = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0, r1, r2, bf, d1r, cnt;
    bit early;
    req_v[0] = 1'b0; ack_v[0] = 1'b0;
    req_v[1] = 1'b0; ack_v[1] = 1'b0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    tick();
    tick();

    // Power-up timing with requests low on both instances.
    aclrn = 1'b1;
    edge_n = 0;
    r0 = -1; r1 = -1; r2 = -1; bf = -1; d1r = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (r0 < 0 && if0.o_resetn[0]) r0 = edge_n;
      if (r1 < 0 && if0.o_resetn[1]) r1 = edge_n;
      if (r2 < 0 && if0.o_resetn[2] && if0.o_all_released) r2 = edge_n;
      if (bf < 0 && !if0.o_busy) bf = edge_n;
      if (d1r < 0 && if1.o_resetn[0] && if1.o_all_released) d1r = edge_n;
    end
    exp_q.push_back(32'(SD0 + H0));
    exp_q.push_back(32'(SD0 + H0 + G0));
    exp_q.push_back(32'(SD0 + H0 + 2 * G0));
    exp_q.push_back(32'(SD0 + H0 + 2 * G0));
    exp_q.push_back(32'(SD1 + H1));
    check("pwr_stage0_edge", 32'(r0), exp_q.pop_front());
    check("pwr_stage1_edge", 32'(r1), exp_q.pop_front());
    check("pwr_stage2_edge", 32'(r2), exp_q.pop_front());
    check("pwr_busy_fall_edge", 32'(bf), exp_q.pop_front());
    check("pwr_d1_release_edge", 32'(d1r), exp_q.pop_front());
    rand1_en = 1'b1;

    // Soft reset, ack five cycles after the quiesce request.
    req_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b0;
    wait_for(0, "ack5_qreq");
    repeat (5) tick();
    ack_v[0] = 1'b1;
    tick();
    ack_v[0] = 1'b0;
    check("ack5_resetn_low", 32'(if0.o_resetn), 32'd0);
    wait_for(2, "ack5_rerelease");
    check("ack5_sticky_clear", 32'(if0.o_timeout_sticky), 32'd0);

    // Soft reset with no ack: the request must last exactly the timeout.
    req_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b0;
    cnt = 0;
    while (if0.o_quiesce_req && cnt < 400) begin
      tick();
      cnt++;
    end
    check("timeout_qreq_cycles", 32'(cnt), 32'(TO0));
    check("timeout_resetn_low", 32'(if0.o_resetn), 32'd0);
    check("timeout_sticky_set", 32'(if0.o_timeout_sticky), 32'd1);
    wait_for(2, "timeout_rerelease");
    check("timeout_sticky_persist", 32'(if0.o_timeout_sticky), 32'd1);

    // Request held high for 50 cycles after the quiesce completes.
    req_v[0] = 1'b1;
    tick();
    wait_for(0, "hold_qreq");
    tick();
    ack_v[0] = 1'b1;
    tick();
    ack_v[0] = 1'b0;
    early = 1'b0;
    repeat (50) begin
      tick();
      if (if0.o_resetn != '0) early = 1'b1;
    end
    check("hold_ext_no_release", 32'(early), 32'd0);
    req_v[0] = 1'b0;
    cnt = 0;
    while (!if0.o_resetn[0] && cnt < 100) begin
      tick();
      cnt++;
    end
    check("hold_ext_release_delay", 32'(cnt), 32'(H0));

    // aclrn mid-release, after stage 1 is out; full sequence must repeat.
    wait_for(3, "mid_release");
    do_aclr();
    wait_for(2, "aclr_rerelease");

    // Ack on exactly the cycle the timeout would fire.
    req_v[0] = 1'b1;
    tick();
    req_v[0] = 1'b0;
    repeat (TO0 - 1) tick();
    ack_v[0] = 1'b1;
    tick();
    ack_v[0] = 1'b0;
    check("ack_on_timeout_sticky", 32'(if0.o_timeout_sticky), 32'd0);
    check("ack_on_timeout_resetn", 32'(if0.o_resetn), 32'd0);
    check("ack_on_timeout_qreq", 32'(if0.o_quiesce_req), 32'd0);

    // Random traffic on both instances with occasional hard resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) req_v[0] = ~req_v[0];
      ack_v[0] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) do_aclr();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
